// File: rtl/cavlc_run_encoder_if.sv
// Handshake bundle between the coefficient source, the run encoder
// and the CAVLC bitstream packer.
interface cavlc_run_encoder_if;
   logic         start;
   logic [143:0] coeff_in;
   logic         busy;
   logic         hdr_valid;
   logic [4:0]   total_coeff;
   logic [3:0]   total_zeros;
   logic         code_valid;
   logic         code_ready;
   logic [10:0]  code_bits;
   logic [3:0]   code_len;
   logic         done;

   modport master (
      output start, coeff_in, code_ready,
      input  busy, hdr_valid, total_coeff, total_zeros,
      input  code_valid, code_bits, code_len, done
   );

   modport slave (
      input  start, coeff_in, code_ready,
      output busy, hdr_valid, total_coeff, total_zeros,
      output code_valid, code_bits, code_len, done
   );
endinterface

// File: rtl/cavlc_run_encoder.sv
// CAVLC run_before encoder: scans a zigzag 4x4 block, reports
// TotalCoeff/total_zeros and emits run_before codewords top-down.
module cavlc_run_encoder (
   input  logic               clk,
   input  logic               reset_n,
   cavlc_run_encoder_if.slave bus
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SCAN = 3'd1;
   localparam logic [2:0] S_HDR  = 3'd2;
   localparam logic [2:0] S_WALK = 3'd3;
   localparam logic [2:0] S_OUT  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   logic [2:0]  state;
   logic [15:0] nz;
   logic [15:0] nz_in;
   logic [3:0]  idx;
   logic [3:0]  last_pos;
   logic [3:0]  p;
   logic [3:0]  zl;
   logic [3:0]  run;
   logic [4:0]  tc;
   logic [4:0]  cl;
   logic [4:0]  total_coeff;
   logic [3:0]  total_zeros;
   logic [10:0] code_bits;
   logic [3:0]  code_len;

   logic        nz_idx;
   logic        nz_p;
   logic [4:0]  tc_fin;
   logic [3:0]  last_fin;
   logic [3:0]  tz_fin;
   logic [10:0] vlc_bits;
   logic [3:0]  vlc_len;

   always_comb begin
      nz_in = '0;
      for (int i = 0; i < 16; i++)
         nz_in[i] = |bus.coeff_in[9*i +: 9];
   end

   assign nz_idx   = nz[idx];
   assign nz_p     = nz[p];
   assign tc_fin   = tc + {4'd0, nz_idx};
   assign last_fin = nz_idx ? idx : last_pos;
   // tc_fin==16 wraps to 0 in 4 bits, giving 15+1-0 = 0 as required
   assign tz_fin   = (tc_fin == 5'd0) ? 4'd0
                   : last_fin + 4'd1 - tc_fin[3:0];

   always_comb begin
      vlc_bits = '0;
      vlc_len  = 4'd1;
      unique case (1'b1)
         (zl == 4'd1): begin
            vlc_bits = {10'd0, run == 4'd0};
            vlc_len  = 4'd1;
         end
         (zl == 4'd2): begin
            vlc_bits = (run == 4'd0) ? 11'd1 : {10'd0, run == 4'd1};
            vlc_len  = (run == 4'd0) ? 4'd1 : 4'd2;
         end
         (zl == 4'd3): begin
            vlc_bits = {7'd0, 4'd3 - run};
            vlc_len  = 4'd2;
         end
         (zl == 4'd4): begin
            vlc_bits = (run < 4'd3) ? {7'd0, 4'd3 - run}
                                    : {10'd0, run == 4'd3};
            vlc_len  = (run < 4'd3) ? 4'd2 : 4'd3;
         end
         (zl == 4'd5): begin
            vlc_bits = (run < 4'd2) ? {7'd0, 4'd3 - run}
                                    : {7'd0, 4'd5 - run};
            vlc_len  = (run < 4'd2) ? 4'd2 : 4'd3;
         end
         (zl == 4'd6): begin
            vlc_len = (run == 4'd0) ? 4'd2 : 4'd3;
            case (run)
               4'd0:    vlc_bits = 11'd3;
               4'd1:    vlc_bits = 11'd0;
               4'd2:    vlc_bits = 11'd1;
               4'd3:    vlc_bits = 11'd3;
               4'd4:    vlc_bits = 11'd2;
               4'd5:    vlc_bits = 11'd5;
               4'd6:    vlc_bits = 11'd4;
               default: vlc_bits = 11'd0;
            endcase
         end
         (zl >= 4'd7): begin
            vlc_bits = (run < 4'd7) ? {7'd0, 4'd7 - run} : 11'd1;
            vlc_len  = (run < 4'd7) ? 4'd3 : run - 4'd3;
         end
         default: begin
            vlc_bits = '0;
            vlc_len  = 4'd1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         nz          <= '0;
         idx         <= '0;
         last_pos    <= '0;
         p           <= '0;
         zl          <= '0;
         run         <= '0;
         tc          <= '0;
         cl          <= '0;
         total_coeff <= '0;
         total_zeros <= '0;
         code_bits   <= '0;
         code_len    <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.start) begin
                  nz       <= nz_in;
                  tc       <= '0;
                  last_pos <= '0;
                  idx      <= '0;
                  state    <= S_SCAN;
               end
            end
            S_SCAN: begin
               tc       <= tc_fin;
               last_pos <= last_fin;
               idx      <= idx + 4'd1;
               if (idx == 4'd15) begin
                  total_coeff <= tc_fin;
                  total_zeros <= tz_fin;
                  state       <= S_HDR;
               end
            end
            S_HDR: begin
               if (total_coeff <= 5'd1 || total_zeros == 4'd0) begin
                  state <= S_DONE;
               end else begin
                  zl    <= total_zeros;
                  cl    <= total_coeff;
                  run   <= '0;
                  p     <= last_pos - 4'd1;
                  state <= S_WALK;
               end
            end
            S_WALK: begin
               p <= p - 4'd1;
               if (nz_p) begin
                  code_bits <= vlc_bits;
                  code_len  <= vlc_len;
                  zl        <= zl - run;
                  cl        <= cl - 5'd1;
                  run       <= '0;
                  state     <= S_OUT;
               end else begin
                  run <= run + 4'd1;
               end
            end
            S_OUT: begin
               // lowest coefficient's run is implied, so stop at cl==1
               if (bus.code_ready)
                  state <= (zl == 4'd0 || cl == 5'd1) ? S_DONE : S_WALK;
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy        = (state != S_IDLE);
   assign bus.hdr_valid   = (state == S_HDR);
   assign bus.code_valid  = (state == S_OUT);
   assign bus.done        = (state == S_DONE);
   assign bus.total_coeff = total_coeff;
   assign bus.total_zeros = total_zeros;
   assign bus.code_bits   = code_bits;
   assign bus.code_len    = code_len;

endmodule

// File: tb/tb_cavlc_run_encoder.sv
// Directed bench for cavlc_run_encoder: header values, codeword
// sequence, stalls, ignored starts, latency and mid-block reset.
module tb_cavlc_run_encoder;

   logic clk;
   logic reset_n;
   int   checks;
   int   failures;
   int   cyc;

   cavlc_run_encoder_if bus ();

   cavlc_run_encoder dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " busy"},  32'(bus.busy), 32'd0);
      check({tag, " hdr"},   32'(bus.hdr_valid), 32'd0);
      check({tag, " tc"},    32'(bus.total_coeff), 32'd0);
      check({tag, " tz"},    32'(bus.total_zeros), 32'd0);
      check({tag, " cv"},    32'(bus.code_valid), 32'd0);
      check({tag, " bits"},  32'(bus.code_bits), 32'd0);
      check({tag, " len"},   32'(bus.code_len), 32'd0);
      check({tag, " done"},  32'(bus.done), 32'd0);
   endtask

   // codes: entry k at [15k +: 15] = {len[3:0], bits[10:0]}
   task automatic encode(input string tag, input logic [143:0] c,
                         input int etc, input int etz, input int n,
                         input logic [59:0] codes, input int stall,
                         input int elat);
      int t0;
      int w;
      logic [14:0] ec;
      bus.coeff_in = c;
      bus.start    = 1'b1;
      step();
      t0 = cyc;
      bus.coeff_in = '0;
      check({tag, " busy"}, 32'(bus.busy), 32'd1);
      bus.start = 1'b1;
      repeat (15) step();
      bus.start = 1'b0;
      check({tag, " hdr early"}, 32'(bus.hdr_valid), 32'd0);
      step();
      check({tag, " hdr"}, 32'(bus.hdr_valid), 32'd1);
      check({tag, " tc"},  32'(bus.total_coeff), 32'(etc));
      check({tag, " tz"},  32'(bus.total_zeros), 32'(etz));
      if (n == 0) begin
         step();
      end
      for (int k = 0; k < n; k++) begin
         ec = codes[15*k +: 15];
         w  = 0;
         while (!bus.code_valid && !bus.done && w < 64) begin
            step();
            w++;
         end
         check({tag, " code present"}, 32'(bus.code_valid), 32'd1);
         check({tag, " bits"}, 32'(bus.code_bits), 32'(ec[10:0]));
         check({tag, " len"},  32'(bus.code_len),  32'(ec[14:11]));
         if (stall > 0) begin
            bus.code_ready = 1'b0;
            bus.start      = 1'b1;
            repeat (stall) begin
               step();
               check({tag, " stall cv"}, 32'(bus.code_valid), 32'd1);
               check({tag, " stall bits"}, 32'(bus.code_bits),
                     32'(ec[10:0]));
               check({tag, " stall len"}, 32'(bus.code_len),
                     32'(ec[14:11]));
            end
            bus.start      = 1'b0;
            bus.code_ready = 1'b1;
         end
         step();
      end
      check({tag, " done"}, 32'(bus.done), 32'd1);
      check({tag, " cv at done"}, 32'(bus.code_valid), 32'd0);
      if (elat >= 0)
         check({tag, " latency"}, 32'(cyc - t0), 32'(elat));
      step();
      check({tag, " done pulse"}, 32'(bus.done), 32'd0);
      check({tag, " idle"}, 32'(bus.busy), 32'd0);
      check({tag, " tc held"}, 32'(bus.total_coeff), 32'(etc));
      step();
   endtask

   logic [143:0] c1;
   logic [143:0] c2;
   logic [143:0] c3;
   logic [143:0] c4;
   logic [143:0] c5;
   logic [59:0]  k1;
   logic [59:0]  k3;
   int           w0;

   initial begin
      checks       = 0;
      failures     = 0;
      cyc          = 0;
      reset_n      = 1'b0;
      bus.start    = 1'b0;
      bus.coeff_in = '0;
      bus.code_ready = 1'b1;

      c1 = '0;
      c1[9*1 +: 9] = 9'd3;
      c1[9*2 +: 9] = 9'h1FF;
      c1[9*5 +: 9] = 9'h1FF;
      c1[9*6 +: 9] = 9'd1;
      c1[9*8 +: 9] = 9'd1;
      k1 = {4'd1, 11'b1, 4'd2, 11'b01, 4'd2, 11'b11, 4'd2, 11'b10};

      c2 = '0;
      c2[9*0 +: 9] = 9'd5;
      c2[9*1 +: 9] = 9'd5;
      c2[9*2 +: 9] = 9'd5;

      c3 = '0;
      c3[9*0 +: 9]  = 9'h100;
      c3[9*15 +: 9] = 9'd7;
      k3 = {45'd0, 4'd11, 11'd1};

      c4 = '0;
      c5 = '0;
      c5[9*9 +: 9] = 9'h1F0;

      step();
      step();
      check_reset_outputs("reset");
      reset_n = 1'b1;
      step();

      encode("t1", c1, 5, 4, 4, k1, 0, 28);
      encode("t2", c2, 3, 0, 0, 60'd0, 0, 17);
      encode("t3", c3, 2, 14, 1, k3, 0, 33);
      encode("t4z", c4, 0, 0, 0, 60'd0, 0, 17);
      encode("t4s", c5, 1, 9, 0, 60'd0, 0, 17);
      encode("t5", c1, 5, 4, 4, k1, 5, 48);

      bus.coeff_in = c1;
      bus.start    = 1'b1;
      step();
      bus.start = 1'b0;
      w0 = 0;
      while (!bus.code_valid && w0 < 64) begin
         step();
         w0++;
      end
      check("rst pre cv", 32'(bus.code_valid), 32'd1);
      reset_n = 1'b0;
      step();
      check_reset_outputs("rst mid");
      reset_n = 1'b1;
      step();

      encode("t6", c3, 2, 14, 1, k3, 0, 33);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
